// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 frame receiver: FSM encoding, frame geometry
// and the parity helper used when a frame is loaded.
package ps2_pkg;

  localparam int DATA_W     = 8;
  localparam int FRAME_BITS = 11;
  // Counter runs from FRAME_BITS-2 (first data bit) down to 0 (stop bit)
  localparam int BITCNT_W   = $clog2(FRAME_BITS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DPS  = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  function automatic logic odd_parity_err(input logic [DATA_W:0] i_bits);
    return ~^i_bits;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Two-flop synchronisers for the PS/2 lines, a shift-register deglitcher on the
// clock, and a registered one-cycle pulse on each filtered falling edge.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_ps2c,
  input  logic i_ps2d,
  output logic o_ps2d_s,
  output logic o_fall_edge
);

  logic                  r_c_s0, r_c_s1;
  logic                  r_d_s0, r_d_s1;
  logic [FILTER_LEN-1:0] r_filt;
  logic                  r_f_val;
  logic                  r_fall;

  // The clock path resets to the idle-high level so that leaving reset never
  // looks like a falling edge (which would otherwise read as a start bit).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_c_s0  <= 1'b1;
      r_c_s1  <= 1'b1;
      r_d_s0  <= 1'b0;
      r_d_s1  <= 1'b0;
      r_filt  <= '1;
      r_f_val <= 1'b1;
      r_fall  <= 1'b0;
    end else begin
      r_c_s0 <= i_ps2c;
      r_c_s1 <= r_c_s0;
      r_d_s0 <= i_ps2d;
      r_d_s1 <= r_d_s0;
      r_filt <= {r_c_s1, r_filt[FILTER_LEN-1:1]};
      r_fall <= r_f_val & ~(|r_filt);
      if (&r_filt)
        r_f_val <= 1'b1;
      else if (~(|r_filt))
        r_f_val <= 1'b0;
    end
  end

  assign o_ps2d_s    = r_d_s1;
  assign o_fall_edge = r_fall;

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 keyboard frame receiver with parity/framing status.
// Optional idle-bit watchdog enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int TO_W        = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ps2c,
  input  logic              ps2d,
  input  logic              rx_en,
  output logic              rx_done_tick,
  output logic [DATA_W-1:0] dout,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  logic                  w_ps2d_s;
  logic                  w_fall;
  logic                  w_timeout;
  logic [FRAME_BITS-2:0] w_b_next;

  logic [1:0]            r_state;
  logic [BITCNT_W-1:0]   r_n;
  logic [FRAME_BITS-2:0] r_b;
  logic [DATA_W-1:0]     r_dout;
  logic                  r_perr;
  logic                  r_ferr;

  if ((TIMEOUT_CYC < 2) || (TO_W < $clog2(TIMEOUT_CYC))) begin : g_bad_to_w
    $error("ps2_frame_rx: TO_W cannot hold TIMEOUT_CYC-1");
  end

  ps2_clk_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filt (
    .clk         (clk),
    .reset       (reset),
    .i_ps2c      (ps2c),
    .i_ps2d      (ps2d),
    .o_ps2d_s    (w_ps2d_s),
    .o_fall_edge (w_fall)
  );

  assign w_b_next = {w_ps2d_s, r_b[FRAME_BITS-2:1]};

`ifdef PS2_RX_TIMEOUT_EN
  logic [TO_W-1:0] r_to;

  always_ff @(posedge clk) begin
    if (reset)
      r_to <= '0;
    else if ((r_state != ST_DPS) || w_fall)
      r_to <= '0;
    else
      r_to <= r_to + 1'b1;
  end

  assign w_timeout = (r_state == ST_DPS) && !w_fall &&
                     (r_to == TO_W'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Status is captured on the stop-bit edge so dout is already valid while
  // rx_done_tick is high in LOAD.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_n     <= '0;
      r_b     <= '0;
      r_dout  <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fall && rx_en && !w_ps2d_s) begin
            r_n     <= BITCNT_W'(FRAME_BITS - 2);
            r_state <= ST_DPS;
          end
        end
        ST_DPS: begin
          if (w_timeout) begin
            r_state <= ST_IDLE;
          end else if (w_fall) begin
            r_b <= w_b_next;
            if (r_n == '0) begin
              r_state <= ST_LOAD;
              r_dout  <= w_b_next[DATA_W-1:0];
              r_perr  <= odd_parity_err(w_b_next[DATA_W:0]);
              r_ferr  <= ~w_b_next[FRAME_BITS-2];
            end else begin
              r_n <= r_n - 1'b1;
            end
          end
        end
        ST_LOAD: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rx_done_tick = (r_state == ST_LOAD);
  assign busy         = (r_state != ST_IDLE);
  assign dout         = r_dout;
  assign parity_err   = r_perr;
  assign frame_err    = r_ferr;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: frames, errors, glitches, enable and reset.
// The watchdog scenario is built only when PS2_RX_TIMEOUT_EN is defined.
module tb_ps2_frame_rx;

  localparam int FLEN = 8;
  localparam int TOC  = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic       rx_en = 1'b0;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  int         n_strobe = 0;
  logic       busy_seen = 1'b0;
  logic [7:0] cap_dout [4];
  logic       cap_perr [4];
  logic       cap_ferr [4];

  ps2_frame_rx #(
    .FILTER_LEN  (FLEN),
    .TIMEOUT_CYC (TOC),
    .TO_W        (17)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2c         (ps2c),
    .ps2d         (ps2d),
    .rx_en        (rx_en),
    .rx_done_tick (rx_done_tick),
    .dout         (dout),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy) busy_seen = 1'b1;
    if (rx_done_tick) begin
      if (n_strobe < 4) begin
        cap_dout[n_strobe] = dout;
        cap_perr[n_strobe] = parity_err;
        cap_ferr[n_strobe] = frame_err;
      end
      n_strobe = n_strobe + 1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    n_strobe  = 0;
    busy_seen = 1'b0;
  endtask

  // Frame bits LSB first: start, d0..d7, parity, stop
  task automatic send_bits(input logic [7:0] d, input logic p, input logic s,
                           input int lo, input int hi);
    logic [10:0] fr;
    fr = {s, p, d, 1'b0};
    for (int i = lo; i <= hi; i++) begin
      ps2d = fr[i];
      cyc(10);
      ps2c = 1'b0;
      cyc(20);
      ps2c = 1'b1;
      cyc(10);
    end
    ps2d = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(5);
    n_checks++; if (rx_done_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b want 0", rx_done_tick); end
    n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h want 00", dout); end
    n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr got %b want 0", parity_err); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got %b want 0", frame_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    reset = 1'b0;
    cyc(20);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy got %b want 0", busy); end
  endtask

  task automatic test_scan_code();
    clear_mon();
    rx_en = 1'b1;
    send_bits(8'h1C, 1'b0, 1'b1, 0, 10);
    cyc(20);
    n_checks++; if (n_strobe !== 1) begin n_fail++; $display("FAIL scan_strobes got %0d want 1", n_strobe); end
    n_checks++; if (cap_dout[0] !== 8'h1C) begin n_fail++; $display("FAIL scan_dout_at_tick got %h want 1c", cap_dout[0]); end
    n_checks++; if (dout !== 8'h1C) begin n_fail++; $display("FAIL scan_dout_hold got %h want 1c", dout); end
    n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL scan_perr got %b want 0", parity_err); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL scan_ferr got %b want 0", frame_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL scan_busy_after got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send_bits(8'hF0, 1'b1, 1'b1, 0, 10);
    send_bits(8'h1C, 1'b0, 1'b1, 0, 10);
    cyc(20);
    n_checks++; if (n_strobe !== 2) begin n_fail++; $display("FAIL b2b_strobes got %0d want 2", n_strobe); end
    n_checks++; if (cap_dout[0] !== 8'hF0) begin n_fail++; $display("FAIL b2b_first got %h want f0", cap_dout[0]); end
    n_checks++; if (cap_dout[1] !== 8'h1C) begin n_fail++; $display("FAIL b2b_second got %h want 1c", cap_dout[1]); end
    n_checks++; if ((cap_perr[0] | cap_ferr[0] | cap_perr[1] | cap_ferr[1]) !== 1'b0) begin
      n_fail++; $display("FAIL b2b_errs got p%b%b f%b%b want 0", cap_perr[0], cap_perr[1], cap_ferr[0], cap_ferr[1]);
    end
  endtask

  task automatic test_parity_error();
    clear_mon();
    send_bits(8'h1C, 1'b1, 1'b1, 0, 10);
    cyc(20);
    n_checks++; if (n_strobe !== 1) begin n_fail++; $display("FAIL perr_strobes got %0d want 1", n_strobe); end
    n_checks++; if (dout !== 8'h1C) begin n_fail++; $display("FAIL perr_dout got %h want 1c", dout); end
    n_checks++; if (parity_err !== 1'b1) begin n_fail++; $display("FAIL perr_flag got %b want 1", parity_err); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL perr_ferr got %b want 0", frame_err); end
  endtask

  task automatic test_frame_error();
    clear_mon();
    send_bits(8'h29, 1'b0, 1'b0, 0, 10);
    cyc(20);
    n_checks++; if (n_strobe !== 1) begin n_fail++; $display("FAIL ferr_strobes got %0d want 1", n_strobe); end
    n_checks++; if (dout !== 8'h29) begin n_fail++; $display("FAIL ferr_dout got %h want 29", dout); end
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_flag got %b want 1", frame_err); end
    n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL ferr_perr got %b want 0", parity_err); end
  endtask

  task automatic test_glitch_and_enable();
    clear_mon();
    rx_en = 1'b1;
    ps2d  = 1'b0;
    cyc(5);
    ps2c = 1'b0;
    cyc(FLEN - 2);
    ps2c = 1'b1;
    cyc(30);
    ps2d = 1'b1;
    n_checks++; if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL glitch_busy got %b want 0", busy_seen); end
    n_checks++; if (n_strobe !== 0) begin n_fail++; $display("FAIL glitch_strobes got %0d want 0", n_strobe); end
    clear_mon();
    rx_en = 1'b0;
    send_bits(8'h1C, 1'b0, 1'b1, 0, 10);
    cyc(20);
    n_checks++; if (n_strobe !== 0) begin n_fail++; $display("FAIL disabled_strobes got %0d want 0", n_strobe); end
    n_checks++; if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL disabled_busy got %b want 0", busy_seen); end
  endtask

  task automatic test_mid_frame();
    clear_mon();
    rx_en = 1'b1;
    send_bits(8'h5A, 1'b1, 1'b1, 0, 3);
    rx_en = 1'b0;
    send_bits(8'h5A, 1'b1, 1'b1, 4, 10);
    cyc(20);
    n_checks++; if (n_strobe !== 1) begin n_fail++; $display("FAIL rxen_drop_strobes got %0d want 1", n_strobe); end
    n_checks++; if (dout !== 8'h5A) begin n_fail++; $display("FAIL rxen_drop_dout got %h want 5a", dout); end
    n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL rxen_drop_perr got %b want 0", parity_err); end

    clear_mon();
    rx_en = 1'b1;
    send_bits(8'h29, 1'b0, 1'b1, 0, 5);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(40);
    n_checks++; if (n_strobe !== 0) begin n_fail++; $display("FAIL midreset_strobes got %0d want 0", n_strobe); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b want 0", busy); end
    n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL midreset_dout got %h want 00", dout); end
    n_checks++; if ((parity_err | frame_err) !== 1'b0) begin n_fail++; $display("FAIL midreset_flags got p%b f%b want 0", parity_err, frame_err); end

    clear_mon();
    send_bits(8'h29, 1'b0, 1'b1, 0, 10);
    cyc(20);
    n_checks++; if (n_strobe !== 1) begin n_fail++; $display("FAIL recover_strobes got %0d want 1", n_strobe); end
    n_checks++; if (dout !== 8'h29) begin n_fail++; $display("FAIL recover_dout got %h want 29", dout); end
    n_checks++; if ((parity_err | frame_err) !== 1'b0) begin n_fail++; $display("FAIL recover_flags got p%b f%b want 0", parity_err, frame_err); end
  endtask

`ifdef PS2_RX_TIMEOUT_EN
  task automatic test_timeout();
    clear_mon();
    rx_en = 1'b1;
    send_bits(8'hF0, 1'b1, 1'b1, 0, 4);
    cyc(100);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL to_still_busy got %b want 1", busy); end
    cyc(150);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_idle got %b want 0", busy); end
    n_checks++; if (n_strobe !== 0) begin n_fail++; $display("FAIL to_strobes got %0d want 0", n_strobe); end
    n_checks++; if (dout !== 8'h29) begin n_fail++; $display("FAIL to_dout_kept got %h want 29", dout); end
    clear_mon();
    send_bits(8'h29, 1'b0, 1'b1, 0, 10);
    cyc(20);
    n_checks++; if (n_strobe !== 1) begin n_fail++; $display("FAIL to_next_strobes got %0d want 1", n_strobe); end
    n_checks++; if (dout !== 8'h29) begin n_fail++; $display("FAIL to_next_dout got %h want 29", dout); end
  endtask
`endif

  initial begin
    test_reset();
    test_scan_code();
    test_back_to_back();
    test_parity_error();
    test_frame_error();
    test_glitch_and_enable();
    test_mid_frame();
`ifdef PS2_RX_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
